// File: rtl/chip8_framebuffer.sv
// Parametrised CHIP-8/SCHIP framebuffer with sprite XOR engine and multi-cycle clear.
// Lo-res draws scale each logical pixel to a 2x2 physical block; hi-res maps 1:1.
module chip8_framebuffer #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 64,
  parameter int WRAP   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hires,
  input  logic                      start,
  input  logic                      clear,
  input  logic [7:0]                x_in,
  input  logic [6:0]                y_in,
  input  logic [3:0]                n_rows,
  output logic                      row_req,
  output logic [3:0]                row_idx,
  input  logic                      row_valid,
  input  logic [15:0]               row_data,
  output logic                      busy,
  output logic                      done,
  output logic                      collision,
  output logic [WIDTH*HEIGHT-1:0]   display,
  output logic [2:0]                dbg_state
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int AW   = $clog2(NPIX);
  localparam int RW   = $clog2(HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FETCH = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        ox_q, ox_d;
  logic [6:0]        oy_q, oy_d;
  logic              hires_q, hires_d;
  logic [3:0]        n_q, n_d;
  logic [15:0]       row_q, row_d;
  logic [3:0]        row_idx_q, row_idx_d;
  logic [RW-1:0]     clr_row_q, clr_row_d;
  logic              coll_q, coll_d;
  logic [NPIX-1:0]   disp_q, disp_d;
  logic [NPIX-1:0]   mask;
  logic              last_row;

  assign last_row = (row_idx_q == ((n_q == 4'd0) ? 4'd15 : (n_q - 4'd1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clear) state_d = S_CLEAR;
               else if (start) state_d = S_FETCH;
      S_CLEAR: if (clr_row_q == RW'(HEIGHT - 1)) state_d = S_DONE;
      S_FETCH: if (row_valid) state_d = S_WRITE;
      S_WRITE: state_d = last_row ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Row fetch handshake: row_req is held high for the whole FETCH state; the
  // first cycle with row_valid=1 transfers row_data, and row_valid is ignored otherwise.
  always_comb begin
    row_req   = (state_q == S_FETCH);
    busy      = (state_q == S_CLEAR) || (state_q == S_FETCH) || (state_q == S_WRITE);
    done      = (state_q == S_DONE);
    dbg_state = state_q;
  end

  assign row_idx   = row_idx_q;
  assign collision = coll_q;
  assign display   = disp_q;

  // Physical pixels touched by the latched row, after wrap/clip and lo-res scaling.
  always_comb begin
    int   lw, lh, lx, ly;
    logic pix_on;
    mask = '0;
    lw   = hires_q ? WIDTH : WIDTH / 2;
    lh   = hires_q ? HEIGHT : HEIGHT / 2;
    for (int k = 0; k < 16; k++) begin
      pix_on = row_q[4'(15 - k)] && ((n_q == 4'd0) || (k < 8));
      lx     = int'(ox_q) + k;
      ly     = int'(oy_q) + int'(row_idx_q);
      if (WRAP != 0) begin
        if (lx >= lw) lx = lx - lw;
        if (ly >= lh) ly = ly - lh;
      end
      if (pix_on && (lx < lw) && (ly < lh)) begin
        if (hires_q) mask[AW'(ly * WIDTH + lx)] = 1'b1;
        else begin
          for (int d = 0; d < 4; d++)
            mask[AW'((2 * ly + d / 2) * WIDTH + 2 * lx + d % 2)] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ox_d      = ox_q;
    oy_d      = oy_q;
    hires_d   = hires_q;
    n_d       = n_q;
    row_d     = row_q;
    row_idx_d = row_idx_q;
    clr_row_d = clr_row_q;
    coll_d    = coll_q;
    disp_d    = disp_q;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          clr_row_d = '0;
          coll_d    = 1'b0;
          hires_d   = hires;
        end else if (start) begin
          ox_d      = hires ? 8'(int'(x_in) % WIDTH) : 8'(int'(x_in) % (WIDTH / 2));
          oy_d      = hires ? 7'(int'(y_in) % HEIGHT) : 7'(int'(y_in) % (HEIGHT / 2));
          hires_d   = hires;
          n_d       = n_rows;
          row_idx_d = 4'd0;
          coll_d    = 1'b0;
        end
      end
      S_CLEAR: begin
        disp_d[clr_row_q * WIDTH +: WIDTH] = '0;
        clr_row_d = clr_row_q + 1'b1;
      end
      S_FETCH: if (row_valid) row_d = row_data;
      S_WRITE: begin
        disp_d    = disp_q ^ mask;
        coll_d    = coll_q | (|(mask & disp_q));
        row_idx_d = row_idx_q + 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ox_q      <= '0;
      oy_q      <= '0;
      hires_q   <= 1'b0;
      n_q       <= '0;
      row_q     <= '0;
      row_idx_q <= '0;
      clr_row_q <= '0;
      coll_q    <= 1'b0;
      disp_q    <= '0;
    end else begin
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      hires_q   <= hires_d;
      n_q       <= n_d;
      row_q     <= row_d;
      row_idx_q <= row_idx_d;
      clr_row_q <= clr_row_d;
      coll_q    <= coll_d;
      disp_q    <= disp_d;
    end
  end

endmodule

// File: tb/tb_chip8_framebuffer.sv
// Bench for chip8_framebuffer: one clipping and one wrapping instance share stimulus;
// a behavioural pixel model feeds expected displays into a scoreboard checked on done.
module tb_chip8_framebuffer;

  localparam int W = 128;
  localparam int H = 64;
  localparam int N = W * H;

  logic          clk = 1'b0;
  logic          reset;
  logic          hires, start, clear;
  logic [7:0]    x_in;
  logic [6:0]    y_in;
  logic [3:0]    n_rows;
  logic          row_valid;
  logic [15:0]   row_data;

  logic          row_req0, row_req1, busy0, busy1, done0, done1, coll0, coll1;
  logic [3:0]    row_idx0, row_idx1;
  logic [N-1:0]  disp0, disp1;
  logic [2:0]    st0, st1;

  logic [15:0]   spr [16];
  int            wait_left;
  logic [N-1:0]  m0, m1;
  logic [N-1:0]  exp_q[$];
  logic [N-1:0]  exp1_q[$];
  logic [1:0]    exp_coll_q[$];
  int            exp_lat_q[$];
  int            n_cmp, n_bad;

  always #5 clk = ~clk;

  chip8_framebuffer #(.WIDTH(W), .HEIGHT(H), .WRAP(0)) dut0 (
    .clk(clk), .reset(reset), .hires(hires), .start(start), .clear(clear),
    .x_in(x_in), .y_in(y_in), .n_rows(n_rows), .row_req(row_req0), .row_idx(row_idx0),
    .row_valid(row_valid), .row_data(row_data), .busy(busy0), .done(done0),
    .collision(coll0), .display(disp0), .dbg_state(st0)
  );

  chip8_framebuffer #(.WIDTH(W), .HEIGHT(H), .WRAP(1)) dut1 (
    .clk(clk), .reset(reset), .hires(hires), .start(start), .clear(clear),
    .x_in(x_in), .y_in(y_in), .n_rows(n_rows), .row_req(row_req1), .row_idx(row_idx1),
    .row_valid(row_valid), .row_data(row_data), .busy(busy1), .done(done1),
    .collision(coll1), .display(disp1), .dbg_state(st1)
  );

  // Sprite memory: answers a request after wait_left idle cycles.
  always @(negedge clk) begin
    if (row_req0) begin
      if (wait_left > 0) begin
        row_valid = 1'b0;
        wait_left--;
      end else begin
        row_valid = 1'b1;
        row_data  = spr[row_idx0];
      end
    end else begin
      row_valid = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cmp_disp(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    for (int r = 0; r < H; r++)
      chk($sformatf("%s row%0d", tag, r), got[r * W +: W], exp[r * W +: W]);
  endtask

  task automatic model_draw(inout logic [N-1:0] d, output logic c, input bit wrap,
                            input logic hr, input int x, input int y, input int n);
    int lw, lh, ox, oy, rows, wid, lx, ly, sc, px, py;
    lw = hr ? W : W / 2;
    lh = hr ? H : H / 2;
    ox = x % lw;
    oy = y % lh;
    rows = (n == 0) ? 16 : n;
    wid  = (n == 0) ? 16 : 8;
    sc   = hr ? 1 : 2;
    c    = 1'b0;
    for (int r = 0; r < rows; r++) begin
      for (int k = 0; k < wid; k++) begin
        if (spr[r][15 - k]) begin
          lx = ox + k;
          ly = oy + r;
          if (wrap) begin
            lx = lx % lw;
            ly = ly % lh;
          end
          if (lx < lw && ly < lh) begin
            for (int dy = 0; dy < sc; dy++) begin
              for (int dx = 0; dx < sc; dx++) begin
                px = lx * sc + dx;
                py = ly * sc + dy;
                if (d[py * W + px]) c = 1'b1;
                d[py * W + px] = ~d[py * W + px];
              end
            end
          end
        end
      end
    end
  endtask

  task automatic issue(input logic c, input logic s, input logic hr, input int x, input int y, input int n);
    @(negedge clk);
    clear  = c;
    start  = s;
    hires  = hr;
    x_in   = 8'(x);
    y_in   = 7'(y);
    n_rows = 4'(n);
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [N-1:0] pre, input int wt, input bit poke);
    int lat;
    bit seen;
    logic [N-1:0] e0, e1;
    logic [1:0] ec;
    int el;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      if (busy0 || done0) lat++;
      if (lat >= 1 && lat <= wt) begin
        chk({tag, " req_hold"}, 128'(row_req0), 128'd1);
        chk({tag, " disp_hold"}, 128'(disp0 === pre), 128'd1);
      end
      if (poke) begin
        start = (lat == 2);
        clear = (lat == 2);
        x_in  = 8'd50;
      end
      if (done0) seen = 1'b1;
      else @(negedge clk);
    end
    chk({tag, " done_seen"}, 128'(seen), 128'd1);
    e0 = exp_q.pop_front();
    e1 = exp1_q.pop_front();
    ec = exp_coll_q.pop_front();
    el = exp_lat_q.pop_front();
    if (seen) begin
      chk({tag, " latency"}, 128'(lat), 128'(el));
      chk({tag, " done1"}, 128'(done1), 128'd1);
      chk({tag, " coll0"}, 128'(coll0), 128'(ec[0]));
      chk({tag, " coll1"}, 128'(coll1), 128'(ec[1]));
      cmp_disp({tag, " d0"}, disp0, e0);
      cmp_disp({tag, " d1"}, disp1, e1);
    end
  endtask

  task automatic draw(input string tag, input logic hr, input int x, input int y,
                      input int n, input int wt, input bit poke);
    logic [N-1:0] pre;
    logic c0, c1;
    int rows;
    pre = m0;
    model_draw(m0, c0, 1'b0, hr, x, y, n);
    model_draw(m1, c1, 1'b1, hr, x, y, n);
    rows = (n == 0) ? 16 : n;
    exp_q.push_back(m0);
    exp1_q.push_back(m1);
    exp_coll_q.push_back({c1, c0});
    exp_lat_q.push_back(2 * rows + wt + 1);
    wait_left = wt;
    issue(1'b0, 1'b1, hr, x, y, n);
    wait_done(tag, pre, wt, poke);
  endtask

  task automatic do_clear(input string tag, input logic also_start);
    m0 = '0;
    m1 = '0;
    exp_q.push_back(m0);
    exp1_q.push_back(m1);
    exp_coll_q.push_back(2'b00);
    exp_lat_q.push_back(H + 1);
    wait_left = 0;
    issue(1'b1, also_start, 1'b1, 3, 3, 1);
    wait_done(tag, m0, 0, 1'b0);
  endtask

  task automatic check_idle(input string tag);
    repeat (3) begin
      @(negedge clk);
      chk({tag, " busy"}, 128'(busy0), 128'd0);
      chk({tag, " state"}, 128'(st0), 128'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; hires = 1'b1; start = 1'b0; clear = 1'b0;
    x_in = '0; y_in = '0; n_rows = '0;
    row_valid = 1'b0; row_data = '0; wait_left = 0;
    m0 = '0; m1 = '0;
    for (int i = 0; i < 16; i++) spr[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst busy", 128'(busy0), 128'd0);
    chk("rst done", 128'(done0), 128'd0);
    chk("rst coll", 128'(coll0), 128'd0);
    chk("rst req", 128'(row_req0), 128'd0);
    chk("rst idx", 128'(row_idx0), 128'd0);
    chk("rst state", 128'(st0), 128'd0);
    cmp_disp("rst", disp0, '0);
    reset = 1'b0;

    // Hi-res draw then identical redraw erases and collides
    do_clear("t2 clr", 1'b0);
    spr[0] = 16'hF000;
    draw("t2 a", 1'b1, 0, 0, 1, 0, 1'b0);
    chk("t2 a bits", 128'(disp0[7:0]), 128'h0F);
    chk("t2 a coll", 128'(coll0), 128'd0);
    draw("t2 b", 1'b1, 0, 0, 1, 0, 1'b0);
    chk("t2 b bits", 128'(disp0[7:0]), 128'h00);
    chk("t2 b coll", 128'(coll0), 128'd1);

    // Lo-res 2x2 scaling
    do_clear("t3 clr", 1'b0);
    spr[0] = 16'h8000;
    draw("t3", 1'b0, 1, 1, 1, 0, 1'b0);
    for (int r = 0; r < 5; r++)
      chk($sformatf("t3 fixed row%0d", r), disp0[r * W +: W], (r == 2 || r == 3) ? 128'hC : 128'h0);

    // Edge clipping versus wrapping
    do_clear("t4 clr", 1'b0);
    spr[0] = 16'hFF00;
    spr[1] = 16'hFF00;
    draw("t4", 1'b1, 126, 63, 2, 0, 1'b0);
    chk("t4 clip row63", disp0[63 * W +: W], {2'b11, 126'b0});
    chk("t4 clip row0", disp0[0 +: W], 128'h0);
    chk("t4 wrap row63", disp1[63 * W +: W], {2'b11, 120'b0, 6'h3F});
    chk("t4 wrap row0", disp1[0 +: W], {2'b11, 120'b0, 6'h3F});

    // Memory stalls five cycles on the first row
    spr[0] = 16'hA5C3; spr[1] = 16'h3C00; spr[2] = 16'hFFFF;
    draw("t5", 1'b1, 10, 5, 3, 5, 1'b0);

    // Clear wins over start; commands while busy are dropped
    do_clear("t6 both", 1'b1);
    check_idle("t6 both idle");
    spr[0] = 16'h1234; spr[1] = 16'h8001;
    draw("t6 poke", 1'b1, 20, 30, 2, 3, 1'b1);
    check_idle("t6 poke idle");

    // Randomised draws across modes, sizes and stalls
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 16; i++) spr[i] = 16'($urandom);
      draw($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 127)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset abandons a draw stalled in FETCH
    do_clear("t1 clr", 1'b0);
    spr[0] = 16'hFFFF;
    draw("t1 pre", 1'b1, 0, 0, 1, 0, 1'b0);
    spr[0] = 16'h00FF;
    wait_left = 50;
    issue(1'b0, 1'b1, 1'b1, 0, 0, 1);
    repeat (2) @(negedge clk);
    chk("t1 fetch req", 128'(row_req0), 128'd1);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("t1 busy", 128'(busy0), 128'd0);
    chk("t1 req", 128'(row_req0), 128'd0);
    chk("t1 state", 128'(st0), 128'd0);
    cmp_disp("t1", disp0, '0);
    reset = 1'b0;
    wait_left = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
